// File: rtl/axi_burst_pkg.sv
// Shared definitions for the AXI write-burst master: FSM state encoding,
// AXI protocol constants and the awsize helper.
package axi_burst_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // awsize encodes log2 of the bytes per beat
  function automatic logic [2:0] calc_awsize(input int data_width);
    int          nbytes;
    logic [2:0]  sz;
    nbytes = data_width / 8;
    sz     = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ((1 << i) == nbytes) sz = 3'(i);
    end
    return sz;
  endfunction

endpackage

// File: rtl/burst_addr_gen.sv
// Burst start-address generator: walks a circular region in fixed steps,
// wrapping back to the base address at the end of the ring.
module burst_addr_gen #(
  parameter int     ADDR_WIDTH   = 32,
  parameter longint BASE_ADDR    = 0,
  parameter longint REGION_BYTES = 4096,
  parameter longint STEP_BYTES   = 64
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  advance,
  output logic [ADDR_WIDTH-1:0] addr
);

  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] END_ADDR = ADDR_WIDTH'(BASE_ADDR + REGION_BYTES);
  localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(STEP_BYTES);

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_inc;

  assign addr_inc = addr_q + STEP;

  always_ff @(posedge aclk) begin
    if (areset) begin
      addr_q <= BASE;
    end else if (advance) begin
      addr_q <= (addr_inc == END_ADDR) ? BASE : addr_inc;
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/axi_write_burst_master.sv
// AXI-Stream to AXI4 write-burst master: one outstanding fixed-length INCR
// burst at a time into a ring region. Optional macro: AXIWM_RESP_CHECK_EN.
module axi_write_burst_master
  import axi_burst_pkg::*;
#(
  parameter int     DATA_WIDTH   = 32,
  parameter int     ADDR_WIDTH   = 32,
  parameter int     BURST_LEN    = 16,
  parameter longint BASE_ADDR    = 0,
  parameter longint REGION_BYTES = 4096
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [ADDR_WIDTH/4-1:0] awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  output logic [15:0]             burst_count,
  output logic                    busy,
  output logic                    resp_err
);

  localparam int     BEAT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int     LEN_W      = ADDR_WIDTH / 4;
  localparam longint STEP_BYTES = longint'(BURST_LEN) * DATA_WIDTH / 8;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  state_e            state_q;
  state_e            state_d;
  logic [BEAT_W-1:0] beat_cnt;
  logic [15:0]       burst_cnt_q;
  logic              in_data;
  logic              aw_hs;
  logic              w_hs;
  logic              b_hs;

  // AW/W/B channel drive: W is a combinational pass-through of the stream
  assign in_data       = (state_q == ST_DATA);
  assign awvalid       = (state_q == ST_ADDR);
  assign wvalid        = in_data && s_axis_tvalid;
  assign s_axis_tready = in_data && wready;
  assign wdata         = s_axis_tdata;
  assign wlast         = in_data && (beat_cnt == LAST_BEAT);
  assign bready        = (state_q == ST_RESP);
  assign busy          = (state_q != ST_IDLE);

  assign awlen   = LEN_W'(BURST_LEN - 1);
  assign awsize  = calc_awsize(DATA_WIDTH);
  assign awburst = AXI_BURST_INCR;
  assign wstrb   = '1;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign b_hs  = bready && bvalid;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (s_axis_tvalid) state_d = ST_ADDR;
      ST_ADDR: if (aw_hs)         state_d = ST_DATA;
      ST_DATA: if (w_hs && wlast) state_d = ST_RESP;
      ST_RESP: if (b_hs)          state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= ST_IDLE;
      beat_cnt    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (aw_hs) begin
        beat_cnt <= '0;
      end else if (w_hs) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
      if (b_hs) burst_cnt_q <= burst_cnt_q + 16'd1;
    end
  end

  assign burst_count = burst_cnt_q;

  burst_addr_gen #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .BASE_ADDR   (BASE_ADDR),
    .REGION_BYTES(REGION_BYTES),
    .STEP_BYTES  (STEP_BYTES)
  ) u_addr_gen (
    .aclk   (aclk),
    .areset (areset),
    .advance(b_hs),
    .addr   (awaddr)
  );

`ifdef AXIWM_RESP_CHECK_EN
  logic        resp_err_q;
  logic [15:0] dbg_err_cnt_q;

  // Sticky error flag plus a saturating debug count of bad responses
  always_ff @(posedge aclk) begin
    if (areset) begin
      resp_err_q    <= 1'b0;
      dbg_err_cnt_q <= '0;
    end else if (b_hs && (bresp != AXI_RESP_OKAY)) begin
      resp_err_q <= 1'b1;
      if (dbg_err_cnt_q != 16'hFFFF) dbg_err_cnt_q <= dbg_err_cnt_q + 16'd1;
    end
  end

  assign resp_err = resp_err_q;
`else
  logic unused_bresp;
  assign unused_bresp = ^bresp;
  assign resp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_axi_write_burst_master.sv
// Scoreboard bench for axi_write_burst_master: a randomized stream driver
// pushes expected AW/W traffic, a monitor pops and compares at handshakes.
module tb_axi_write_burst_master;

  localparam int     DW     = 32;
  localparam int     AW     = 32;
  localparam int     BL     = 4;
  localparam longint BASE   = 'h1000;
  localparam longint REGION = 32;
  localparam longint STEP   = BL * DW / 8;

  logic          aclk = 1'b0;
  logic          areset;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [AW-1:0] awaddr;
  logic [7:0]    awlen;
  logic [2:0]    awsize;
  logic [1:0]    awburst;
  logic          awvalid;
  logic          awready;
  logic [DW-1:0] wdata;
  logic [3:0]    wstrb;
  logic          wlast;
  logic          wvalid;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;
  logic [15:0]   burst_count;
  logic          busy;
  logic          resp_err;

  always #5 aclk = ~aclk;

  axi_write_burst_master #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .BURST_LEN   (BL),
    .BASE_ADDR   (BASE),
    .REGION_BYTES(REGION)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .awaddr       (awaddr),
    .awlen        (awlen),
    .awsize       (awsize),
    .awburst      (awburst),
    .awvalid      (awvalid),
    .awready      (awready),
    .wdata        (wdata),
    .wstrb        (wstrb),
    .wlast        (wlast),
    .wvalid       (wvalid),
    .wready       (wready),
    .bresp        (bresp),
    .bvalid       (bvalid),
    .bready       (bready),
    .burst_count  (burst_count),
    .busy         (busy),
    .resp_err     (resp_err)
  );

  int          cmp_cnt = 0;
  int          mis_cnt = 0;
  logic [31:0] exp_aw[$];
  logic [31:0] exp_wd[$];
  logic        exp_wl[$];
  int          word_idx   = 0;
  int          burst_idx  = 0;
  int          exp_bursts = 0;
  logic        exp_err    = 1'b0;
  int          wr_mode    = 0;
  int          b_delay    = 0;
  logic [1:0]  cur_bresp  = 2'b00;
  logic        b_busy     = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    cmp_cnt++;
    mis_cnt++;
    $display("FAIL %s: timed out", name);
  endtask

  // k-th burst since reset lands at the k-th slot of the ring
  function automatic logic [31:0] exp_addr(input int k);
    return 32'(BASE + (longint'(k) * STEP) % REGION);
  endfunction

  // Slave ready behaviour: always, alternating, or random
  initial begin
    awready = 1'b0;
    wready  = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      awready = (wr_mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      case (wr_mode)
        0:       wready = 1'b1;
        1:       wready = ~wready;
        default: wready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops expected AW and W traffic at every handshake
  initial begin
    logic [31:0] e_d;
    logic        e_l;
    forever begin
      @(negedge aclk);
      if (!areset) begin
        if (awvalid) check("aw_w_exclusive", wvalid, 0);
        if (awvalid && awready) begin
          if (exp_aw.size() == 0) begin
            cmp_cnt++;
            mis_cnt++;
            $display("FAIL aw_unexpected: got awaddr 0x%0h, expected no AW", awaddr);
          end else begin
            check("awaddr", awaddr, exp_aw.pop_front());
            check("awlen", awlen, BL - 1);
            check("awsize", awsize, 2);
            check("awburst", awburst, 1);
          end
        end
        if (wvalid && wready) begin
          if (exp_wd.size() == 0) begin
            cmp_cnt++;
            mis_cnt++;
            $display("FAIL w_unexpected: got wdata 0x%0h, expected no beat", wdata);
          end else begin
            e_d = exp_wd.pop_front();
            e_l = exp_wl.pop_front();
            check("wdata", wdata, e_d);
            check("wlast", wlast, e_l);
            check("wstrb", wstrb, 4'hF);
          end
        end
      end
    end
  end

  // B responder: answers each completed burst after a delay, checks counters
  initial begin
    int         d;
    logic [1:0] r;
    bit         ok;
    bvalid = 1'b0;
    bresp  = 2'b00;
    forever begin
      @(negedge aclk);
      if (!areset && wvalid && wready && wlast) begin
        b_busy = 1'b1;
        d = (b_delay < 0) ? int'($urandom_range(0, 3)) : b_delay;
        r = cur_bresp;
        @(posedge aclk);
        for (int i = 0; i < d; i++) begin
          @(negedge aclk);
          check("stall_bready", bready, 1);
          check("stall_tready", s_axis_tready, 0);
          check("stall_awvalid", awvalid, 0);
          @(posedge aclk);
        end
        #1;
        bvalid = 1'b1;
        bresp  = r;
        ok = 0;
        for (int c = 0; c < 100; c++) begin
          @(negedge aclk);
          if (bready) begin
            ok = 1;
            break;
          end
        end
        if (!ok) timeout("b_handshake");
        @(posedge aclk);
        #1;
        bvalid = 1'b0;
        bresp  = 2'b00;
        if (ok) begin
          exp_bursts++;
`ifdef AXIWM_RESP_CHECK_EN
          if (r != 2'b00) exp_err = 1'b1;
`endif
        end
        check("burst_count", burst_count, 64'(exp_bursts % 65536));
        check("resp_err", resp_err, exp_err);
        check("busy_after_b", busy, 0);
        b_busy = 1'b0;
      end
    end
  end

  // Presents n words; expected AW is queued with the first word of each burst
  task automatic send_words(input int n, input int gap_lo, input int gap_hi,
                            input bit fixed, input logic [31:0] base_val);
    logic [31:0] d;
    bit          ok;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(gap_hi, gap_lo)) @(posedge aclk);
      #1;
      d = fixed ? base_val + 32'(i) : $urandom;
      s_axis_tdata  = d;
      s_axis_tvalid = 1'b1;
      if (word_idx % BL == 0) begin
        exp_aw.push_back(exp_addr(burst_idx));
        burst_idx++;
      end
      exp_wd.push_back(d);
      exp_wl.push_back(word_idx % BL == BL - 1);
      word_idx++;
      ok = 0;
      for (int c = 0; c < 300; c++) begin
        @(negedge aclk);
        if (s_axis_tready) begin
          ok = 1;
          break;
        end
      end
      if (!ok) timeout("stream_accept");
      @(posedge aclk);
      #1;
      s_axis_tvalid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge aclk);
      if (!busy && !b_busy && !bvalid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout("wait_idle");
    @(posedge aclk);
    #1;
  endtask

  initial begin
    areset        = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_bready", bready, 0);
    check("rst_tready", s_axis_tready, 0);
    check("rst_busy", busy, 0);
    check("rst_burst_count", burst_count, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_awaddr", awaddr, BASE);
    areset = 1'b0;

    // single burst of known words
    wr_mode = 0;
    b_delay = 0;
    send_words(4, 0, 0, 1, 32'hA0);
    wait_idle();

    // back-to-back bursts across the ring wrap
    send_words(8, 0, 0, 0, 0);
    wait_idle();

    // backpressure: alternating wready, 2-cycle stream gaps
    wr_mode = 1;
    send_words(16, 2, 2, 0, 0);
    wait_idle();

    // random ready, gaps and response delays
    wr_mode = 2;
    b_delay = -1;
    send_words(12, 0, 3, 0, 0);
    wait_idle();

    // long response stall with the next burst already waiting upstream
    wr_mode = 0;
    b_delay = 10;
    send_words(8, 0, 0, 0, 0);
    wait_idle();

    // error response followed by an OKAY burst
    b_delay   = 1;
    cur_bresp = 2'b10;
    send_words(4, 0, 0, 0, 0);
    wait_idle();
    cur_bresp = 2'b00;
    send_words(4, 0, 1, 0, 0);
    wait_idle();

    // reset after two of four beats
    send_words(2, 0, 0, 0, 0);
    areset = 1'b1;
    @(posedge aclk);
    #1;
    check("midrst_wvalid", wvalid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_awvalid", awvalid, 0);
    check("midrst_burst_count", burst_count, 0);
    check("midrst_resp_err", resp_err, 0);
    check("midrst_awaddr", awaddr, BASE);
    exp_aw.delete();
    exp_wd.delete();
    exp_wl.delete();
    word_idx   = 0;
    burst_idx  = 0;
    exp_bursts = 0;
    exp_err    = 1'b0;
    areset     = 1'b0;
    send_words(4, 0, 0, 0, 0);
    wait_idle();

    check("aw_queue_drained", exp_aw.size(), 0);
    check("w_queue_drained", exp_wd.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule
